bilateral_line_arbiter: RTL and testbench
=========================================

BILATERAL_LINE_ARBITER -- requirements
Module: bilateral_line_arbiter

Interface
REQ-001 Parameters: disp_bits default 5, disparity width in bits; line_width default 640, pixels per line; frame_height default 480, lines per frame; tag_depth default 4, line-tag FIFO entries (power of 2).
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 s_valid  in  2  per-requester pixel valid; bit r belongs to requester r (r = 0 left eye, r = 1 right eye).
REQ-005 s_ready  out  2  per-requester ready; a pixel transfers when s_valid[r] and s_ready[r] are both high.
REQ-006 s_disparity  in  2*disp_bits  requester r in bits [r*disp_bits +: disp_bits].
REQ-007 s_confidence, s_gray  in  16 each  requester r in bits [r*8 +: 8].
REQ-008 f_disparity  out  disp_bits; f_confidence, f_gray  out  8 each: pixel data to the shared 3x1 bilateral filter.
REQ-009 f_first_pixel_in_line, f_last_pixel_in_line, f_last_pixel_in_frame, f_in_valid  out  1 each: filter sideband and strobe.
REQ-010 f_out_valid  in  1  filter output strobe, one per filtered pixel, in input order.
REQ-011 out_id  out  1 (requester of the current filter output); out_eol  out  1 (last pixel of line); out_eof  out  1 (last pixel of frame); all qualified by f_out_valid.

Function
REQ-012 FSM states: IDLE, STREAM, GAP; transitions occur only on clk rising edges.
REQ-013 IDLE: when any s_valid is high and the tag FIFO is not full, grant requester g and go to STREAM. If both are valid, g = the requester not granted last; after reset, requester 0 wins the first tie.
REQ-014 On grant, push tag {g, row[g]==frame_height-1} into the tag FIFO in the same cycle.
REQ-015 STREAM: s_ready[g] = 1 and s_ready[other] = 0. Each transfer drives f_in_valid = 1 with the granted data, registered with 1-cycle latency, and increments col.
REQ-016 Mid-line bubbles (s_valid[g] = 0) are allowed: f_in_valid = 0 and the grant is held. Lines are never interrupted or preempted.
REQ-017 f_first_pixel_in_line = (col == 0); f_last_pixel_in_line = (col == line_width-1); f_last_pixel_in_frame = f_last_pixel_in_line, asserted on every line end to force the filter's one-shift flush so each line drains completely.
REQ-018 On the transfer with col == line_width-1: col <= 0; row[g] <= row[g]+1, wrapping to 0 after frame_height-1; last_grant <= g; go to GAP.
REQ-019 GAP lasts exactly 1 cycle with s_ready = 0 and f_in_valid = 0, then returns to IDLE.
REQ-020 Outside STREAM, s_ready = 0; f_in_valid = 0 and all f_* sideband = 0.
REQ-021 Output tagging: on each f_out_valid, out_id is the head tag's id. An output counter ocnt increments; when ocnt == line_width-1, out_eol = 1, out_eof = head eof bit, the tag pops, and ocnt <= 0.
REQ-022 out_id, out_eol and out_eof are combinational from the FIFO head and ocnt.
REQ-023 A push and a pop in the same cycle are legal and leave the occupancy unchanged. A full FIFO blocks grants (REQ-013). f_out_valid while the FIFO is empty is an error: ignore it; the bench shall flag it.
REQ-024 Widths: col and ocnt are $clog2(line_width) bits; each row counter is $clog2(frame_height) bits.

Reset
REQ-025 While reset_n = 0 at a rising edge: state <= IDLE; col, ocnt, row[0], row[1] <= 0; last_grant <= 1; tag FIFO emptied; all registered f_* outputs <= 0.
REQ-026 During and immediately after reset: s_ready = 0, f_in_valid = 0, out_id = 0, out_eol = 0, out_eof = 0.
REQ-027 Reset asserted mid-line aborts the line with no flush. The environment shall also reset the filter.

Verification
REQ-028 line_width = 4; only s_valid[0] held high -> s_ready[0] high for 4 cycles; f_first on pixel 0; f_last_pixel_in_line and f_last_pixel_in_frame on pixel 3; 1 GAP cycle; next grant on the following cycle.
REQ-029 Both requesters continuously valid -> line grants alternate 0,1,0,1 with the first to 0; s_ready is never high on both bits.
REQ-030 Requester 0 drops s_valid for 3 cycles mid-line while requester 1 is valid -> grant stays on 0 and f_in_valid has a 3-cycle hole; col resumes and no pixel is lost or duplicated.
REQ-031 frame_height = 2; two lines from requester 1 -> second tag eof = 1; out_eof asserts only on the 8th f_out_valid; row[1] returns to 0.
REQ-032 f_out_valid held low with tag_depth = 4 -> after 4 grants, IDLE stalls with s_ready = 0 until one line of outputs pops a tag.
REQ-033 reset_n pulsed low at col = 2 -> next cycle s_ready = 0 and all counters 0; first grant after release goes to requester 0.

Source files
------------

// File: rtl/bilateral_line_arbiter.sv
// bilateral_line_arbiter: line-granular two-eye arbiter feeding one shared 3x1 bilateral filter,
// with a tag FIFO that labels each filtered output with its requester and line/frame end.
module bilateral_line_arbiter #(
  parameter int disp_bits    = 5,
  parameter int line_width   = 640,
  parameter int frame_height = 480,
  parameter int tag_depth    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             s_valid,
  output logic [1:0]             s_ready,
  input  logic [2*disp_bits-1:0] s_disparity,
  input  logic [15:0]            s_confidence,
  input  logic [15:0]            s_gray,
  output logic [disp_bits-1:0]   f_disparity,
  output logic [7:0]             f_confidence,
  output logic [7:0]             f_gray,
  output logic                   f_first_pixel_in_line,
  output logic                   f_last_pixel_in_line,
  output logic                   f_last_pixel_in_frame,
  output logic                   f_in_valid,
  input  logic                   f_out_valid,
  output logic                   out_id,
  output logic                   out_eol,
  output logic                   out_eof
);
  localparam int CW = $clog2(line_width);
  localparam int RW = $clog2(frame_height);
  localparam int AW = $clog2(tag_depth);
  localparam int PW = AW + 1;
  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;
  state_t state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d;
  logic [CW-1:0] col_q, col_d, ocnt_q, ocnt_d;
  logic [RW-1:0] row_q [2];
  logic [RW-1:0] row_d [2];
  logic [PW-1:0] wr_q, rd_q;
  logic [1:0] tag_q [tag_depth];
  logic empty, full, push, pop, xfer, eol_in, g;
  always_comb begin
    empty   = wr_q == rd_q;
    full    = (wr_q - rd_q) == PW'(tag_depth);
    g       = &s_valid ? ~last_q : s_valid[1];
    push    = state_q == IDLE && |s_valid && !full;
    xfer    = state_q == STREAM && s_valid[gnt_q];
    eol_in  = col_q == CW'(line_width - 1);
    s_ready = state_q == STREAM ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    out_id  = !empty && tag_q[rd_q[AW-1:0]][1];
    out_eol = !empty && ocnt_q == CW'(line_width - 1);
    out_eof = out_eol && tag_q[rd_q[AW-1:0]][0];
    pop     = f_out_valid && out_eol;
    ocnt_d  = (f_out_valid && !empty) ? (pop ? '0 : ocnt_q + 1'b1) : ocnt_q;
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE: if (push) begin
        gnt_d   = g;
        state_d = STREAM;
      end
      STREAM: if (xfer) begin
        col_d = eol_in ? '0 : col_q + 1'b1;
        if (eol_in) begin
          row_d[gnt_q] = row_q[gnt_q] == RW'(frame_height - 1) ? '0 : row_q[gnt_q] + 1'b1;
          last_d       = gnt_q;
          state_d      = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Tag storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_q[AW-1:0]] <= {g, row_q[g] == RW'(frame_height - 1)};
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q               <= IDLE;
      gnt_q                 <= 1'b0;
      last_q                <= 1'b1;
      col_q                 <= '0;
      ocnt_q                <= '0;
      row_q[0]              <= '0;
      row_q[1]              <= '0;
      wr_q                  <= '0;
      rd_q                  <= '0;
      f_in_valid            <= 1'b0;
      f_first_pixel_in_line <= 1'b0;
      f_last_pixel_in_line  <= 1'b0;
      f_last_pixel_in_frame <= 1'b0;
      f_disparity           <= '0;
      f_confidence          <= '0;
      f_gray                <= '0;
    end else begin
      state_q               <= state_d;
      gnt_q                 <= gnt_d;
      last_q                <= last_d;
      col_q                 <= col_d;
      ocnt_q                <= ocnt_d;
      row_q                 <= row_d;
      wr_q                  <= wr_q + PW'(push);
      rd_q                  <= rd_q + PW'(pop);
      f_in_valid            <= xfer;
      f_first_pixel_in_line <= xfer && col_q == '0;
      f_last_pixel_in_line  <= xfer && eol_in;
      // Every line end also flags frame end so the filter flushes each line completely.
      f_last_pixel_in_frame <= xfer && eol_in;
      f_disparity           <= xfer ? (gnt_q ? s_disparity[2*disp_bits-1 -: disp_bits] : s_disparity[disp_bits-1:0]) : '0;
      f_confidence          <= xfer ? (gnt_q ? s_confidence[15:8] : s_confidence[7:0]) : '0;
      f_gray                <= xfer ? (gnt_q ? s_gray[15:8] : s_gray[7:0]) : '0;
    end
  end
endmodule

// File: tb/tb_bilateral_line_arbiter.sv
// tb_bilateral_line_arbiter: random and directed stimulus against a line-level reference model;
// expected filter pixels and output tags are queued and popped by a negedge monitor.
module tb_bilateral_line_arbiter;
  localparam int DB = 5, LW = 4, FH = 2, TD = 4;
  logic clk = 0, reset_n = 0;
  logic [1:0] s_valid = 0, s_ready;
  logic [2*DB-1:0] s_disparity = 0;
  logic [15:0] s_confidence = 0, s_gray = 0;
  logic [DB-1:0] f_disparity;
  logic [7:0] f_confidence, f_gray;
  logic f_first_pixel_in_line, f_last_pixel_in_line, f_last_pixel_in_frame, f_in_valid;
  logic f_out_valid = 0, out_id, out_eol, out_eof;
  int n_chk = 0, n_fail = 0, pending = 0, grants = 0;
  int owner = -1, pix = 0, gap = 0, last = 1, tag_cnt = 0;
  int rows [2] = '{0, 0};
  bit out_en = 1, rst_prev = 0;
  logic [23:0] fq [$];
  logic [2:0] oq [$];
  logic [1:0] prev;

  bilateral_line_arbiter #(.disp_bits(DB), .line_width(LW), .frame_height(FH), .tag_depth(TD)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_disparity(s_disparity), .s_confidence(s_confidence), .s_gray(s_gray),
    .f_disparity(f_disparity), .f_confidence(f_confidence), .f_gray(f_gray),
    .f_first_pixel_in_line(f_first_pixel_in_line), .f_last_pixel_in_line(f_last_pixel_in_line),
    .f_last_pixel_in_frame(f_last_pixel_in_frame), .f_in_valid(f_in_valid),
    .f_out_valid(f_out_valid), .out_id(out_id), .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [23:0] pe;
    logic [2:0] oe;
    int g, popped;
    if (!reset_n) begin
      if (rst_prev) chk("reset_outputs", {s_ready, f_in_valid, out_id, out_eol, out_eof}, 0);
      rst_prev = 1; owner = -1; pix = 0; gap = 0; last = 1; rows = '{0, 0}; tag_cnt = 0;
      fq.delete(); oq.delete();
    end else begin
      rst_prev = 0;
      popped = 0;
      if (fq.size() > 0) begin
        pe = fq.pop_front();
        chk("filter_pixel", {f_in_valid, f_disparity, f_confidence, f_gray,
            f_first_pixel_in_line, f_last_pixel_in_line, f_last_pixel_in_frame}, {1'b1, pe});
      end else chk("filter_idle", f_in_valid, 0);
      chk("s_ready", s_ready, owner < 0 ? 0 : (owner == 1 ? 2 : 1));
      chk("ready_onehot", s_ready == 2'b11, 0);
      if (f_out_valid) begin
        if (oq.size() > 0) begin
          oe = oq.pop_front();
          popped = oe[1];
          chk("out_tag", {out_id, out_eol, out_eof}, oe);
        end else begin
          $display("note: f_out_valid with empty tag FIFO at %0t is ignored", $time);
          chk("out_tag_empty", {out_id, out_eol, out_eof}, 0);
        end
      end
      // Reference: a line belongs to one owner until LW pixels pass, then one gap cycle, then an arbitration cycle.
      if (owner >= 0) begin
        if (s_valid[owner]) begin
          fq.push_back({s_disparity[owner*DB +: DB], s_confidence[owner*8 +: 8], s_gray[owner*8 +: 8],
                        pix == 0, pix == LW - 1, pix == LW - 1});
          pix++;
          if (pix == LW) begin
            rows[owner] = (rows[owner] + 1) % FH;
            last = owner; owner = -1; pix = 0; gap = 1;
          end
        end
      end else if (gap > 0) gap = 0;
      else if (s_valid != 0 && tag_cnt < TD) begin
        g = (s_valid == 2'b11) ? 1 - last : int'(s_valid[1]);
        tag_cnt++;
        for (int i = 0; i < LW; i++) oq.push_back({g[0], i == LW - 1, i == LW - 1 && rows[g] == FH - 1});
        owner = g;
      end
      tag_cnt -= popped;
    end
  end

  task automatic step(input logic [1:0] v);
    @(posedge clk); #1;
    if (f_in_valid) pending++;
    s_valid = v;
    s_disparity = 10'($urandom);
    s_confidence = 16'($urandom);
    s_gray = 16'($urandom);
    f_out_valid = out_en && pending > 0 && $urandom_range(0, 3) != 0;
    if (f_out_valid) pending--;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 0; s_valid = 0; f_out_valid = 0; pending = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic wait_ready(input logic [1:0] v, input logic [1:0] want, input string nm);
    for (int i = 0; i < 30 && s_ready == 0; i++) step(v);
    chk(nm, s_ready, want);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    f_out_valid = 1;
    step(0);
    repeat (14) step(2'b01);
    do_reset();
    wait_ready(2'b11, 2'b01, "first_tie_to_r0");
    repeat (40) step(2'b11);
    do_reset();
    wait_ready(2'b11, 2'b01, "grant_before_hole");
    step(2'b11);
    repeat (3) step(2'b10);
    repeat (20) step(2'b11);
    do_reset();
    out_en = 0;
    grants = 0;
    for (int i = 0; i < 40; i++) begin
      prev = s_ready;
      step(2'b11);
      if (prev == 0 && s_ready != 0) grants++;
    end
    chk("stall_grants", grants, 4);
    chk("stall_ready", s_ready, 0);
    out_en = 1;
    repeat (40) step(2'b11);
    repeat (300) step(2'($urandom_range(0, 3)));
    do_reset();
    wait_ready(2'b11, 2'b01, "grant_before_abort");
    step(2'b11);
    do_reset();
    wait_ready(2'b11, 2'b01, "grant_after_abort");
    for (int i = 0; i < 20; i++) step(owner < 0 ? 2'b00 : (owner == 1 ? 2'b10 : 2'b01));
    repeat (80) step(2'b00);
    chk("drain_out_queue", oq.size(), 0);
    chk("drain_pixel_queue", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
